// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter and sequencer for a shared single-port RAM.
// Latency: grant at edge E, RAM access in the next cycle, ack one cycle later; requesters hold req until ack.
module ram_rr_arbiter #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              ack0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata1,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout
);

   localparam logic IDLE   = 1'b0;
   localparam logic ACCESS = 1'b1;

   logic              state;
   logic              owner;
   logic              last_grant;
   logic              cmd_we;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              elig0;
   logic              elig1;
   logic              grant0;
   logic              grant1;

   // A requester still showing its ack has just been served; its held req is not a new command yet.
   assign elig0  = req0 & ~ack0;
   assign elig1  = req1 & ~ack1;
   assign grant0 = elig0 & (~elig1 | last_grant);
   assign grant1 = elig1 & (~elig0 | ~last_grant);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         cmd_we     <= 1'b0;
         cmd_addr   <= '0;
         cmd_wdata  <= '0;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         rdata0     <= '0;
         rdata1     <= '0;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         if (state == IDLE) begin
            if (grant0 | grant1) begin
               owner     <= grant1;
               cmd_we    <= grant1 ? we1    : we0;
               cmd_addr  <= grant1 ? addr1  : addr0;
               cmd_wdata <= grant1 ? wdata1 : wdata0;
               state     <= ACCESS;
            end
         end else begin
            if (owner) begin
               ack1 <= 1'b1;
               if (!cmd_we) rdata1 <= ram_dout;
            end else begin
               ack0 <= 1'b1;
               if (!cmd_we) rdata0 <= ram_dout;
            end
            last_grant <= owner;
            state      <= IDLE;
         end
      end
   end

   // rst_n gates the strobe so a reset landing on the access cycle suppresses the RAM write.
   assign ram_we   = cmd_we & (state == ACCESS) & rst_n;
   assign ram_addr = cmd_addr;
   assign ram_din  = cmd_wdata;

endmodule

// File: doc/ram_rr_arbiter.md
Name: ram_rr_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the shared 8x8 single-port RAM (asynchronous read, synchronous write on posedge clk).
- Each requester posts a read or write command and holds it until acknowledged.
- The block owns the RAM's we/addr/din and samples its dout.
- Sits between the RAM instance and two client datapaths.

Parameters:
- DATA_W, 8, RAM word width.
- ADDR_W, 3, RAM address width (depth 2**ADDR_W).

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst_n  input  1  synchronous active-low reset.
- req0  input  1  requester 0 command valid; held until ack0.
- we0  input  1  requester 0: 1=write, 0=read.
- addr0  input  ADDR_W  requester 0 address.
- wdata0  input  DATA_W  requester 0 write data.
- ack0  output  1  one-cycle completion pulse to requester 0.
- rdata0  output  DATA_W  requester 0 read data; valid when ack0=1 for a read.
- req1  input  1  requester 1 command valid.
- we1  input  1  requester 1: 1=write, 0=read.
- addr1  input  ADDR_W  requester 1 address.
- wdata1  input  DATA_W  requester 1 write data.
- ack1  output  1  completion pulse to requester 1.
- rdata1  output  DATA_W  requester 1 read data.
- ram_we  output  1  RAM write enable.
- ram_addr  output  ADDR_W  RAM address.
- ram_din  output  DATA_W  RAM write data.
- ram_dout  input  DATA_W  RAM asynchronous read data.

Behaviour:
- Reset (rst_n=0 at posedge clk, synchronous only):
  - state=IDLE.
  - ack0=ack1=0; rdata0=rdata1=0.
  - ram_we=0, ram_addr=0, ram_din=0.
  - last_grant=1, so requester 0 wins the first contention.
  - Reset mid-ACCESS aborts: no write is issued on that edge and no ack follows.
- State machine, 2 states: IDLE and ACCESS.
- IDLE:
  - eligible0 = req0 & ~ack0; eligible1 = req1 & ~ack1. A requester whose ack is high this cycle is masked, so a still-asserted req is not re-granted.
  - Neither eligible: stay IDLE.
  - Exactly one eligible: grant it.
  - Both eligible: grant the requester != last_grant.
  - On grant, at posedge: latch the winner's we/addr/wdata into the command register, set owner, go to ACCESS.
- ACCESS (exactly one cycle):
  - ram_addr=cmd_addr; ram_din=cmd_wdata; ram_we=cmd_we.
  - All three are driven from registers, never combinationally from req inputs.
  - At posedge: if read, rdata[owner] <= ram_dout; ack[owner] <= 1; last_grant <= owner; go to IDLE.
- Outside ACCESS: ram_we=0; ram_addr/ram_din hold their last values.
- ack is a single-cycle registered pulse in the IDLE cycle after ACCESS; the other ack stays 0.
- rdataN changes only on a read completion for N; write completions leave it unchanged.
- Latency: req sampled at edge E → RAM access in cycle E+1 → ack high in cycle E+2.
- Throughput: max one access per 2 cycles. With both requesters continuously requesting, grants strictly alternate.
- Requester contract: hold req/we/addr/wdata stable until the cycle ack is seen. Changing the command after grant is harmless, because the latched copy is used.
- Read-after-write to the same address by either requester returns the new data, because accesses are serialized.
- Fairness: no requester waits more than one other access once its req is asserted.

Test Plan:
- Reset: rst_n=0 for 2 cycles with req0=req1=1 → ack0=ack1=0, ram_we=0, rdata0=rdata1=0; after release, first grant goes to requester 0.
- Single write/read: req0 writes addr=5 data=0xA5 (ack0 at cycle+2, ram_we high exactly one cycle with ram_addr=5, ram_din=0xA5); then req0 reads addr=5 → ack0 with rdata0=0xA5.
- Contention: both assert at the same edge; req0 writes addr=2 data=0x11, req1 reads addr=2 → requester 0 served first; requester 1 acked 2 cycles later with rdata1=0x11.
- Round-robin: both hold req continuously for 8 transactions → acks alternate 0,1,0,1…; no back-to-back ack to the same requester while the other is pending.
- Ack masking: req0 held high one cycle past ack0 with req1 idle → no duplicate grant on the ack cycle; a second access starts only from the next cycle.
- Reset mid-operation: assert rst_n=0 on the ACCESS cycle of a write of 0xFF to addr=7 → no ack issued; a subsequent read of addr=7 returns the prior contents.
